pot_spi_master: RTL



---
 rtl/pot_spi_master_if.sv | 22 ++
 rtl/pot_spi_master.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pot_spi_master_if.sv
// rtl/pot_spi_master_if.sv - upstream request/response and SPI pin bundle for pot_spi_master
interface pot_spi_master_if;
  logic        send_data_spi;
  logic [15:0] dat_spi_in;
  logic        send_ok_strobe;
  logic        pot_busy;
  logic [15:0] rd_data;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  send_data_spi, dat_spi_in, spi_miso,
    output send_ok_strobe, pot_busy, rd_data, spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    output send_data_spi, dat_spi_in, spi_miso,
    input  send_ok_strobe, pot_busy, rd_data, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/pot_spi_master.sv
// rtl/pot_spi_master.sv - SPI mode-0 master serialising the 16-bit potentiometer word
module pot_spi_master #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_,
  pot_spi_master_if.master bus
);
  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    half_q, half_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   in_q, in_d;
  logic [15:0]   rd_q, rd_d;
  logic          armed_q, armed_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          stb_q, stb_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      shift_q <= '0;
      in_q    <= '0;
      rd_q    <= '0;
      armed_q <= 1'b1;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      shift_q <= shift_d;
      in_q    <= in_d;
      rd_q    <= rd_d;
      armed_q <= armed_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    shift_d = shift_q;
    in_d    = in_q;
    rd_d    = rd_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    stb_d   = stb_q;
    busy_d  = busy_q;
    // A held request must be seen low once before it can start another frame.
    armed_d = armed_q | ~bus.send_data_spi;

    case (state_q)
      IDLE: begin
        if (bus.send_data_spi && armed_q) begin
          shift_d = bus.dat_spi_in;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          armed_d = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          sclk_d  = 1'b1;
          in_d    = {in_q[14:0], bus.spi_miso};
          cnt_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          half_d = half_q + 5'd1;
          if (half_q == 5'd31) begin
            state_d = HOLD;
          end else if (sclk_q) begin
            // Zero fill leaves mosi low once the 16th bit has gone out.
            sclk_d  = 1'b0;
            shift_d = {shift_q[14:0], 1'b0};
          end else begin
            sclk_d = 1'b1;
            in_d   = {in_q[14:0], bus.spi_miso};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          stb_d   = 1'b1;
          rd_d    = in_q;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        stb_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.spi_cs_n       = cs_n_q;
  assign bus.spi_sclk       = sclk_q;
  assign bus.spi_mosi       = shift_q[15];
  assign bus.send_ok_strobe = stb_q;
  assign bus.pot_busy       = busy_q;
  assign bus.rd_data        = rd_q;
endmodule
